// File: rtl/puf_pkg.sv
// Shared definitions for the PUF response collector: FSM state encoding and
// default run parameters.
package puf_pkg;

  localparam int unsigned DefRespBits    = 16;
  localparam int unsigned DefMeasCycles  = 256;
  localparam int unsigned DefSettleCycles = 4;
  localparam int unsigned DefVotes       = 3;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StMeasure,
    StSample,
    StDone
  } puf_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/puf_bit_sync.sv
// Two-flop synchronizer bringing the asynchronous PUF output into the clk domain.
module puf_bit_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/puf_resp_collector.sv
// Drives a ring-oscillator PUF through settle/measure/sample phases per challenge
// pair and majority-votes several measurements into each response bit.
module puf_resp_collector
  import puf_pkg::*;
#(
  parameter int unsigned RESP_BITS     = DefRespBits,
  parameter int unsigned MEAS_CYCLES   = DefMeasCycles,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
  parameter int unsigned VOTES         = DefVotes
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [2*RESP_BITS-1:0] challenge_i,
  output logic                   puf_enable_o,
  output logic [1:0]             puf_challenge_o,
  input  logic                   puf_bit_i,
  output logic                   busy_o,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [RESP_BITS-1:0]   response_o
);

  localparam int unsigned IdxW    = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned VoteW   = $clog2(VOTES + 1);
  localparam int unsigned MaxLoad = max3(SETTLE_CYCLES - 1, MEAS_CYCLES - 1, 1);
  localparam int unsigned CntW    = (MaxLoad > 1) ? $clog2(MaxLoad + 1) : 1;

  localparam logic [CntW-1:0]  ArmLoad    = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0]  MeasLoad   = CntW'(MEAS_CYCLES - 1);
  localparam logic [CntW-1:0]  SampleLoad = CntW'(1);
  localparam logic [VoteW-1:0] VotesVal   = VoteW'(VOTES);
  localparam logic [VoteW-1:0] HalfVotes  = VoteW'(VOTES / 2);
  localparam logic [IdxW-1:0]  LastIdx    = IdxW'(RESP_BITS - 1);

  puf_state_e state_q, state_d;

  logic [2*RESP_BITS-1:0] chal_q, chal_d;
  logic [RESP_BITS-1:0]   resp_q, resp_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [VoteW-1:0]       votes_q, votes_d;
  logic [VoteW-1:0]       ones_q, ones_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic             puf_bit_s;
  logic [VoteW-1:0] votes_inc;
  logic [VoteW-1:0] ones_inc;
  logic             active;

  puf_bit_sync u_bit_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (puf_bit_i),
    .q_o    (puf_bit_s)
  );

  // Vote/ones counts never exceed VOTES, so these sums cannot wrap.
  assign votes_inc = votes_q + VoteW'(1);
  assign ones_inc  = ones_q + VoteW'(puf_bit_s);

  always_comb begin
    state_d = state_q;
    chal_d  = chal_q;
    resp_d  = resp_q;
    idx_d   = idx_q;
    votes_d = votes_q;
    ones_d  = ones_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StArm;
          chal_d  = challenge_i;
          resp_d  = '0;
          idx_d   = '0;
          votes_d = '0;
          ones_d  = '0;
          cnt_d   = ArmLoad;
        end
      end

      StArm: begin
        if (cnt_q == '0) begin
          state_d = StMeasure;
          cnt_d   = MeasLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StMeasure: begin
        if (cnt_q == '0) begin
          state_d = StSample;
          cnt_d   = SampleLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StSample: begin
        if (cnt_q == '0) begin
          cnt_d = ArmLoad;
          if (votes_inc == VotesVal) begin
            resp_d[idx_q] = (ones_inc > HalfVotes);
            votes_d       = '0;
            ones_d        = '0;
            idx_d         = idx_q + IdxW'(1);
            state_d       = (idx_q == LastIdx) ? StDone : StArm;
          end else begin
            votes_d = votes_inc;
            ones_d  = ones_inc;
            state_d = StArm;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StDone: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      chal_q  <= '0;
      resp_q  <= '0;
      idx_q   <= '0;
      votes_q <= '0;
      ones_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      chal_q  <= chal_d;
      resp_q  <= resp_d;
      idx_q   <= idx_d;
      votes_q <= votes_d;
      ones_q  <= ones_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them without a clock.
  assign active          = (state_q == StArm) || (state_q == StMeasure) ||
                           (state_q == StSample);
  assign puf_enable_o    = (state_q == StMeasure) || (state_q == StSample);
  assign puf_challenge_o = active ? chal_q[{idx_q, 1'b0} +: 2] : 2'b00;
  assign busy_o          = (state_q != StIdle);
  assign resp_valid_o    = (state_q == StDone);
  assign response_o      = resp_q;

endmodule

// File: tb/tb_puf_resp_collector.sv
// Scoreboard bench for puf_resp_collector with a behavioural PUF output model.
module tb_puf_resp_collector;

  localparam int unsigned RB  = 4;
  localparam int unsigned MC  = 8;
  localparam int unsigned SC  = 2;
  localparam int unsigned VT  = 3;
  localparam int unsigned NV  = RB * VT;
  localparam int          LAT = 1 + RB * VT * (SC + MC + 2);

  typedef struct {
    logic [RB-1:0] resp;
    int            start_cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [2*RB-1:0] challenge;
  logic            puf_enable;
  logic [1:0]      puf_challenge;
  logic            puf_bit = 1'b0;
  logic            busy;
  logic            resp_valid;
  logic            resp_ready;
  logic [RB-1:0]   response;

  int            n_cmp = 0;
  int            n_mis = 0;
  int            cyc = 0;
  exp_t          sb[$];
  logic          vote_bits[NV];
  logic [2*RB-1:0] chal_exp = '0;

  puf_resp_collector #(
    .RESP_BITS     (RB),
    .MEAS_CYCLES   (MC),
    .SETTLE_CYCLES (SC),
    .VOTES         (VT)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .challenge_i     (challenge),
    .puf_enable_o    (puf_enable),
    .puf_challenge_o (puf_challenge),
    .puf_bit_i       (puf_bit),
    .busy_o          (busy),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .response_o      (response)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic majority(input int b);
    int ones = 0;
    for (int v = 0; v < VT; v++) ones += int'(vote_bits[b * VT + v]);
    return ones > VT / 2;
  endfunction

  // PUF model: new bit value per measurement; also tracks which pair should be selected.
  int   vote_ptr = 0;
  logic en_prev = 1'b0;
  always @(posedge clk) begin
    int bi;
    logic [2*RB-1:0] sh;
    #1;
    if (!busy) begin
      vote_ptr = 0;
    end else if (!resp_valid) begin
      if (puf_enable && !en_prev && vote_ptr < NV) begin
        puf_bit = vote_bits[vote_ptr];
        vote_ptr++;
      end
      bi = puf_enable ? (vote_ptr - 1) / VT : vote_ptr / VT;
      sh = chal_exp >> (2 * bi);
      check_eq("puf_challenge", 64'(puf_challenge), 64'(sh[1:0]));
    end
    en_prev = puf_enable;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 400 && !resp_valid; i++) tick();
    check_eq("valid_seen", 64'(resp_valid), 64'(1));
  endtask

  task automatic run_one(input logic [2*RB-1:0] chal, input bit busy_poke);
    exp_t e;
    exp_t got;
    for (int b = 0; b < RB; b++) e.resp[b] = majority(b);
    e.start_cyc = cyc;
    sb.push_back(e);
    chal_exp  = chal;
    challenge = chal;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    challenge = ~chal;
    if (busy_poke) begin
      repeat (40) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_valid();
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check_eq("response", 64'(response), 64'(got.resp));
      check_eq("latency", 64'(cyc - got.start_cyc), 64'(LAT));
    end else begin
      check_eq("sb_empty", 64'(1), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RB-1:0] held;
    rst_n      = 1'b0;
    start      = 1'b0;
    challenge  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < NV; i++) vote_bits[i] = 1'b1;
    repeat (3) tick();
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_enable", 64'(puf_enable), 64'(0));
    check_eq("rst_valid", 64'(resp_valid), 64'(0));
    check_eq("rst_response", 64'(response), 64'(0));
    check_eq("rst_chal", 64'(puf_challenge), 64'(0));
    rst_n = 1'b1;
    tick();

    // All-ones PUF, stepping challenge pairs 0..3.
    run_one(8'b11_10_01_00, 1'b0);
    check_eq("a_resp_const", 64'(response), 64'(4'b1111));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check_eq("a_idle_busy", 64'(busy), 64'(0));
    check_eq("a_idle_valid", 64'(resp_valid), 64'(0));

    // Mixed votes, start poked mid-run, consumer stalls.
    vote_bits = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    run_one(8'($urandom), 1'b1);
    check_eq("b_low_bits", 64'(response[1:0]), 64'(2'b01));
    held = response;
    for (int i = 0; i < 50; i++) begin
      start = (i % 10 == 3);
      tick();
      check_eq("b_hold_valid", 64'(resp_valid), 64'(1));
      check_eq("b_hold_resp", 64'(response), 64'(held));
    end
    start      = 1'b1;
    resp_ready = 1'b1;
    tick();
    start      = 1'b0;
    resp_ready = 1'b0;
    check_eq("b_hs_busy", 64'(busy), 64'(0));
    check_eq("b_hs_valid", 64'(resp_valid), 64'(0));
    repeat (5) begin
      tick();
      check_eq("b_idle_busy", 64'(busy), 64'(0));
      check_eq("b_idle_resp", 64'(response), 64'(held));
    end

    // Reset mid-measure once a response bit has been set.
    for (int i = 0; i < NV; i++) vote_bits[i] = 1'b1;
    chal_exp  = 8'($urandom);
    challenge = chal_exp;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 400 && !(response[0] && puf_enable); i++) tick();
    check_eq("c_mid_measure", 64'(response[0] && puf_enable), 64'(1));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("c_rst_enable", 64'(puf_enable), 64'(0));
    check_eq("c_rst_busy", 64'(busy), 64'(0));
    check_eq("c_rst_response", 64'(response), 64'(0));
    check_eq("c_rst_valid", 64'(resp_valid), 64'(0));
    check_eq("c_rst_chal", 64'(puf_challenge), 64'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      check_eq("c_no_valid", 64'(resp_valid), 64'(0));
      check_eq("c_no_busy", 64'(busy), 64'(0));
    end

    // Random votes with the consumer always ready.
    for (int i = 0; i < NV; i++) vote_bits[i] = 1'($urandom);
    resp_ready = 1'b1;
    run_one(8'($urandom), 1'b0);
    tick();
    check_eq("d_idle_busy", 64'(busy), 64'(0));
    check_eq("d_idle_valid", 64'(resp_valid), 64'(0));
    resp_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/puf_resp_collector.md
PUF_RESP_COLLECTOR -- requirements
Module: puf_resp_collector

Interface
REQ-001 SHALL have parameter RESP_BITS, default 16: number of response bits collected per run (1..64).
REQ-002 SHALL have parameter MEAS_CYCLES, default 256: clk cycles that puf_enable is held high per measurement (>=1).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4: clk cycles that puf_enable is held low before each measurement (>=1).
REQ-004 SHALL have parameter VOTES, default 3: measurements per response bit, majority-voted; odd only, 1..7.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic in this block is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1: one-cycle request to begin a run; honoured only in IDLE.
REQ-008 SHALL have port challenge, input, 2*RESP_BITS: challenge vector; bits [2i+1:2i] select the oscillator pair for response bit i.
REQ-009 SHALL have port puf_enable, output, 1: drives the generator's enable; each low-to-high edge clears its counters.
REQ-010 SHALL have port puf_challenge, output, 2: drives the generator's control_input.
REQ-011 SHALL have port puf_bit, input, 1: generator output_signal; asynchronous to clk.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port resp_valid, output, 1: response is complete and stable.
REQ-014 SHALL have port resp_ready, input, 1: consumer accepts response when high together with resp_valid.
REQ-015 SHALL have port response, output, RESP_BITS: collected response; bit i from challenge pair i.

Function
REQ-016 SHALL implement FSM states IDLE, ARM, MEASURE, SAMPLE, DONE.
REQ-017 IDLE: start=1 -> latch challenge, clear response, bit_idx=0, vote count=0, ones count=0; go to ARM next cycle.
REQ-018 ARM: puf_enable=0 for exactly SETTLE_CYCLES cycles, then MEASURE.
REQ-019 MEASURE: puf_enable=1 for exactly MEAS_CYCLES cycles, then SAMPLE.
REQ-020 SAMPLE: puf_enable stays 1; lasts exactly 2 cycles to cover synchronizer latency; on its last cycle the synchronized puf_bit is added to the ones count.
REQ-021 After SAMPLE, votes taken < VOTES -> ARM, same bit_idx.
REQ-022 After SAMPLE, votes taken = VOTES -> response[bit_idx] = (ones > VOTES/2); clear vote and ones counts; bit_idx increments.
REQ-023 If that bit_idx was RESP_BITS-1, go to DONE; otherwise go to ARM.
REQ-024 puf_challenge SHALL equal latched challenge[2*bit_idx+1:2*bit_idx] throughout ARM, MEASURE and SAMPLE; it SHALL not change while puf_enable=1.
REQ-025 DONE: resp_valid=1 and puf_enable=0; response held constant; resp_ready=1 -> IDLE next cycle with resp_valid=0.
REQ-026 resp_valid SHALL first rise exactly 1 + RESP_BITS*VOTES*(SETTLE_CYCLES+MEAS_CYCLES+2) cycles after the cycle start is sampled in IDLE (12577 at defaults).
REQ-027 start outside IDLE SHALL be ignored, including start coincident with the resp_valid&resp_ready handshake.
REQ-028 response SHALL retain its last value in IDLE until the next accepted start.
REQ-029 Ones counter SHALL be ceil(log2(VOTES+1)) bits and SHALL not wrap; bit_idx SHALL be wide enough for RESP_BITS.
REQ-030 puf_bit SHALL pass through a 2-flop synchronizer before any use.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, puf_enable=0, puf_challenge=0, busy=0, resp_valid=0, response=0, and all counters and synchronizer flops to 0.
REQ-032 Reset mid-run SHALL abandon the run without producing resp_valid; after release the block SHALL wait in IDLE for a new start.
REQ-033 Deassertion of rst_n SHALL take effect at the next clk edge; no state SHALL advance on the deasserting edge.

Structure
REQ-034 Shared package puf_pkg SHALL hold the FSM state enumeration and the default values for RESP_BITS, MEAS_CYCLES, SETTLE_CYCLES and VOTES.
REQ-035 Sub-module puf_bit_sync (2-flop synchronizer, async active-low reset) SHALL be instantiated once for puf_bit.
REQ-036 One down-counter SHALL be shared by the ARM, MEASURE and SAMPLE phases, reloaded at each state entry.

Verification
REQ-037 Behavioural PUF model with puf_bit tied to 1, RESP_BITS=4, MEAS_CYCLES=8, SETTLE_CYCLES=2, VOTES=3, start pulse -> resp_valid at start+1+4*3*12=start+145, response=4'b1111.
REQ-038 challenge=8'b11_10_01_00 -> puf_challenge steps 0,1,2,3; each value is held for 36 cycles; there is no change while puf_enable=1.
REQ-039 puf_bit pattern 1,0,1 for bit 0 and 0,0,1 for bit 1 (VOTES=3) -> response[1:0]=2'b01.
REQ-040 resp_ready held low for 50 cycles after resp_valid -> response and resp_valid stable; start pulses ignored; IDLE one cycle after resp_ready=1.
REQ-041 rst_n pulsed low mid-MEASURE -> puf_enable=0, busy=0 and response=0 immediately without a clk edge; no resp_valid until a new start.
REQ-042 start asserted while busy -> no restart and no change to the latched challenge; completion timing is per REQ-026.
